wbu_commit: RTL

Parametrised writeback/commit stage for the ysyx core, sitting after the LSU and driving the register file, the CSR file, and the fetch redirect path. It buffers completed instructions in a small in-order commit queue with valid/ready backpressure, retires at most one per cycle, and squashes wrong-path entries on redirect. It also counts retired instructions and latches a halt on ebreak.

---
 rtl/wbu_commit_if.sv | 31 +++
 rtl/wbu_commit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wbu_commit_if.sv
// Upstream beat bus into the writeback/commit stage: one completed
// instruction per accepted beat, valid/ready handshake.
interface wbu_commit_if #(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 4,
    parameter int CSR_AW = 12
);
    logic              i_valid;
    logic              o_ready;
    logic [XLEN-1:0]   i_pc;
    logic [XLEN-1:0]   i_pc_next;
    logic [XLEN-1:0]   i_res;
    logic              i_wen;
    logic [RF_AW-1:0]  i_rd_addr;
    logic              i_csr_wen;
    logic [CSR_AW-1:0] i_csr_addr;
    logic              i_redir;
    logic              i_ebreak;

    modport master (
        output i_valid, i_pc, i_pc_next, i_res, i_wen, i_rd_addr,
               i_csr_wen, i_csr_addr, i_redir, i_ebreak,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_pc, i_pc_next, i_res, i_wen, i_rd_addr,
               i_csr_wen, i_csr_addr, i_redir, i_ebreak,
        output o_ready
    );
endinterface

// File: rtl/wbu_commit.sv
// Writeback/commit stage: small in-order commit queue, one retire per
// cycle, squash on redirect, sticky halt on ebreak, retire counter.
module wbu_commit #(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 4,
    parameter int CSR_AW = 12,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 64
) (
    input  logic              clock,
    input  logic              reset,
    wbu_commit_if.slave       up,
    input  logic              i_stall,
    output logic              o_rf_wen,
    output logic [RF_AW-1:0]  o_rf_waddr,
    output logic [XLEN-1:0]   o_rf_wdata,
    output logic              o_csr_wen,
    output logic [CSR_AW-1:0] o_csr_waddr,
    output logic [XLEN-1:0]   o_csr_wdata,
    output logic              o_redirect_valid,
    output logic [XLEN-1:0]   o_redirect_pc,
    output logic              o_retire_valid,
    output logic [XLEN-1:0]   o_retire_pc,
    output logic [CNT_W-1:0]  o_retire_cnt,
    output logic              o_halt
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_next;
        logic [XLEN-1:0]   res;
        logic              wen;
        logic [RF_AW-1:0]  rd_addr;
        logic              csr_wen;
        logic [CSR_AW-1:0] csr_addr;
        logic              redir;
        logic              ebreak;
    } entry_t;

    entry_t           q_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;

    entry_t head_s;
    entry_t in_s;
    logic   empty_s;
    logic   full_s;
    logic   ready_s;
    logic   pop_s;
    logic   flush_s;
    logic   push_s;

    // Queue status, handshake and pop/push/flush decisions.
    always_comb begin
        head_s          = q_r[rd_ptr_r[IDX_W-1:0]];
        in_s.pc         = up.i_pc;
        in_s.pc_next    = up.i_pc_next;
        in_s.res        = up.i_res;
        in_s.wen        = up.i_wen;
        in_s.rd_addr    = up.i_rd_addr;
        in_s.csr_wen    = up.i_csr_wen;
        in_s.csr_addr   = up.i_csr_addr;
        in_s.redir      = up.i_redir;
        in_s.ebreak     = up.i_ebreak;
        empty_s         = (wr_ptr_r == rd_ptr_r);
        full_s          = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                          (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
        // Ready depends on state only, never on i_valid.
        ready_s         = !full_s && !o_halt && !o_redirect_valid;
        pop_s           = 1'b0;
        if (!empty_s && !i_stall && !o_halt) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        flush_s         = pop_s && head_s.redir;
        // A beat offered while a redirect retires is wrong-path: drop it.
        push_s          = up.i_valid && ready_s && !flush_s;
    end

    assign up.o_ready = ready_s;

    // Commit-queue payload storage; contents are don't-care when not valid.
    always_ff @(posedge clock) begin
        if (push_s) begin
            q_r[wr_ptr_r[IDX_W-1:0]] <= in_s;
        end
    end

    // Read/write pointers; a redirect retire empties the queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush_s) begin
            rd_ptr_r <= wr_ptr_r;
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
        end
    end

    // Registered commit outputs, retire counter and sticky halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            o_rf_wen         <= 1'b0;
            o_rf_waddr       <= '0;
            o_rf_wdata       <= '0;
            o_csr_wen        <= 1'b0;
            o_csr_waddr      <= '0;
            o_csr_wdata      <= '0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_retire_valid   <= 1'b0;
            o_retire_pc      <= '0;
            o_retire_cnt     <= '0;
            o_halt           <= 1'b0;
        end else begin
            o_rf_wen         <= pop_s && head_s.wen && (head_s.rd_addr != '0);
            o_csr_wen        <= pop_s && head_s.csr_wen;
            o_redirect_valid <= flush_s;
            o_retire_valid   <= pop_s;
            if (pop_s) begin
                o_rf_waddr    <= head_s.rd_addr;
                o_rf_wdata    <= head_s.res;
                o_csr_waddr   <= head_s.csr_addr;
                o_csr_wdata   <= head_s.res;
                o_redirect_pc <= head_s.pc_next;
                o_retire_pc   <= head_s.pc;
                o_retire_cnt  <= o_retire_cnt + CNT_W'(1);
                o_halt        <= o_halt || head_s.ebreak;
            end
        end
    end
endmodule
